// File: rtl/pll_lock_supervisor.sv
// Turns the raw PLL lock into a sequenced, glitch-free active-low reset for one clock domain.
// Latency: rst_out_n rises SYNC_STAGES+1+STABLE_CYCLES+RST_HOLD edges after locked_raw rises; falls SYNC_STAGES+1 edges after it drops.
// Backpressure: none; locked_raw and clr_err are level-sampled on every clk edge.
//
// Ports:
//   clk, rst_n   domain clock, asynchronous active-low reset
//   locked_raw   PLL lock, asynchronous to clk (synchronised internally)
//   clr_err      synchronous clear of lost / lost_cnt
//   rst_out_n    registered downstream reset, low until the lock has qualified
//   ready        same value as rst_out_n (high only in RUN)
//   lost         sticky flag: lock dropped while in RUN
//   lost_cnt     saturating count of RUN lock losses
//   state        0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN
//
// Optional build macro PLL_SUP_GLITCH_FILTER_EN: when defined, RUN only exits
// after the synchronised lock reads low on two consecutive edges.

module pll_lock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int RST_HOLD      = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked_raw,
  input  logic             clr_err,
  output logic             rst_out_n,
  output logic             ready,
  output logic             lost,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [1:0]       state
);

  localparam int MAX_CYC = (STABLE_CYCLES > RST_HOLD) ? STABLE_CYCLES : RST_HOLD;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 st;
  state_t                 nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [CW-1:0]          cnt;
  logic                   loss_evt;
`ifdef PLL_SUP_GLITCH_FILTER_EN
  logic                   low_q;    // lock_s was low on the previous RUN edge
`endif

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign state  = st;

  // Next-state decision; lock_s low always takes priority over the counter.
  always_comb begin
    nxt      = st;
    loss_evt = 1'b0;
    case (st)
      WAIT_LOCK: begin
        if (lock_s) nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s)                nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST) nxt = HOLD;
      end
      HOLD: begin
        if (!lock_s)               nxt = WAIT_LOCK;
        else if (cnt == HOLD_LAST) nxt = RUN;
      end
      RUN: begin
`ifdef PLL_SUP_GLITCH_FILTER_EN
        if (!lock_s && low_q) begin
`else
        if (!lock_s) begin
`endif
          nxt      = WAIT_LOCK;
          loss_evt = 1'b1;
        end
      end
      default: nxt = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      st        <= WAIT_LOCK;
      cnt       <= '0;
      rst_out_n <= 1'b0;
      ready     <= 1'b0;
      lost      <= 1'b0;
      lost_cnt  <= '0;
`ifdef PLL_SUP_GLITCH_FILTER_EN
      low_q     <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_raw};
      st     <= nxt;

      // Counter only advances while qualifying; any state change restarts it.
      if (nxt != st || st == WAIT_LOCK || st == RUN)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      // Registered from next state so the reset edge lines up with the state edge.
      rst_out_n <= (nxt == RUN);
      ready     <= (nxt == RUN);

      // A loss on the same edge as clr_err wins: the clear is applied first,
      // then this loss is counted on top of it.
      if (loss_evt) begin
        lost <= 1'b1;
        if (clr_err)
          lost_cnt <= CNT_W'(1);
        else if (!(&lost_cnt))
          lost_cnt <= lost_cnt + 1'b1;
      end else if (clr_err) begin
        lost     <= 1'b0;
        lost_cnt <= '0;
      end

`ifdef PLL_SUP_GLITCH_FILTER_EN
      // Only tracks while staying in RUN, so entering RUN starts it clear.
      if (st == RUN && nxt == RUN)
        low_q <= ~lock_s;
      else
        low_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with SYNC_STAGES=2, STABLE_CYCLES=8, RST_HOLD=4.
// Two instances share stimulus: one with an 8-bit loss counter, one with a
// 2-bit counter so saturation is reachable. Expected snapshots are queued per edge.

module tb_pll_lock_supervisor;

  localparam int SYNC = 2;
  localparam int STAB = 8;
  localparam int HOLDC = 4;
`ifdef PLL_SUP_GLITCH_FILTER_EN
  localparam int LOSS_LAT = SYNC + 2;
`else
  localparam int LOSS_LAT = SYNC + 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       locked_raw;
  logic       clr_err;
  logic       r8, y8, l8, r2, y2, l2;
  logic [7:0] cnt8;
  logic [1:0] cnt2, st8, st2;

  pll_lock_supervisor #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .RST_HOLD(HOLDC), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .locked_raw(locked_raw), .clr_err(clr_err),
    .rst_out_n(r8), .ready(y8), .lost(l8), .lost_cnt(cnt8), .state(st8)
  );

  pll_lock_supervisor #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .RST_HOLD(HOLDC), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .locked_raw(locked_raw), .clr_err(clr_err),
    .rst_out_n(r2), .ready(y2), .lost(l2), .lost_cnt(cnt2), .state(st2)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   c8     = 0;   // expected lost_cnt, 8-bit instance
  int   c2     = 0;   // expected lost_cnt, 2-bit instance

  function automatic logic [19:0] obs();
    return {st8, r8, y8, l8, cnt8, st2, r2, y2, l2, cnt2};
  endfunction

  // Queue an expected snapshot for absolute edge 'at' using the current model counts.
  task automatic push(input int at, input string nm, input logic [1:0] s, input logic r, input logic l);
    exp_t e;
    e.cyc  = at;
    e.name = nm;
    e.v    = {s, r, r, l, 8'(c8), s, r, r, l, 2'(c2)};
    sb.push_back(e);
  endtask

  task automatic model_loss();
    c8 = (c8 == 255) ? 255 : c8 + 1;
    c2 = (c2 == 3) ? 3 : c2 + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    exp_t e;
    int   base;
    rst_n      = 1'b0;
    locked_raw = 1'b0;
    clr_err    = 1'b0;
    #1;
    n_chk++;
    if (obs() !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_initial: observed %h, required %h", obs(), 20'h0);
    end
    base = cyc;
    for (int k = 1; k <= 4; k++) push(base + k, "reset_idle", 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL %s edge %0d: observed %h, required %h", e.name, cyc, obs(), e.v);
        end
      end
      if (k == 2) rst_n = 1'b1;
    end
  endtask

  // Lock drops during STABLE (cnt=5) and during HOLD restart silently.
  task automatic test_qual_drop();
    exp_t e;
    int   base;
    int   hi_seen;
    hi_seen    = 0;
    base       = cyc;
    locked_raw = 1'b1;
    push(base + 3,  "qual_stable_entry", 2'd1, 1'b0, 1'b0);
    push(base + 8,  "qual_stable_cnt5",  2'd1, 1'b0, 1'b0);
    push(base + 9,  "qual_stable_drop",  2'd0, 1'b0, 1'b0);
    push(base + 12, "qual_restable",     2'd1, 1'b0, 1'b0);
    push(base + 20, "qual_hold_entry",   2'd2, 1'b0, 1'b0);
    push(base + 22, "qual_hold_still",   2'd2, 1'b0, 1'b0);
    push(base + 23, "qual_hold_drop",    2'd0, 1'b0, 1'b0);
    push(base + 26, "qual_idle",         2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (r8 !== 1'b0 || r2 !== 1'b0) hi_seen++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL %s edge %0d: observed %h, required %h", e.name, cyc, obs(), e.v);
        end
      end
      if (k == 6)  locked_raw = 1'b0;
      if (k == 9)  locked_raw = 1'b1;
      if (k == 20) locked_raw = 1'b0;
    end
    n_chk++;
    if (hi_seen !== 0) begin
      n_fail++;
      $display("FAIL qual_no_release: observed %0d high cycles, required 0", hi_seen);
    end
  endtask

  task automatic test_lock_up();
    exp_t e;
    int   base;
    base       = cyc;
    locked_raw = 1'b1;
    push(base + 2,  "up_sync_wait", 2'd0, 1'b0, 1'b0);
    push(base + 3,  "up_stable",    2'd1, 1'b0, 1'b0);
    push(base + 10, "up_stable_end", 2'd1, 1'b0, 1'b0);
    push(base + 11, "up_hold",      2'd2, 1'b0, 1'b0);
    push(base + 14, "up_hold_end",  2'd2, 1'b0, 1'b0);
    push(base + 15, "up_run",       2'd3, 1'b1, 1'b0);
    push(base + 16, "up_run_stay",  2'd3, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL %s edge %0d: observed %h, required %h", e.name, cyc, obs(), e.v);
        end
      end
    end
  endtask

  task automatic test_run_loss();
    exp_t e;
    int   base;
    base       = cyc;
    locked_raw = 1'b0;
    push(base + LOSS_LAT - 1, "loss_pending", 2'd3, 1'b1, 1'b0);
    model_loss();
    push(base + LOSS_LAT,      "loss_exit",   2'd0, 1'b0, 1'b1);
    push(base + LOSS_LAT + 14, "loss_rehold", 2'd2, 1'b0, 1'b1);
    push(base + LOSS_LAT + 15, "loss_rerun",  2'd3, 1'b1, 1'b1);
    for (int k = 1; k <= LOSS_LAT + 15; k++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL %s edge %0d: observed %h, required %h", e.name, cyc, obs(), e.v);
        end
      end
      if (k == LOSS_LAT) locked_raw = 1'b1;
    end
  endtask

  task automatic test_clr_err();
    exp_t e;
    int   base;
    base    = cyc;
    clr_err = 1'b1;
    c8 = 0;
    c2 = 0;
    push(base + 1, "clr_alone",      2'd3, 1'b1, 1'b0);
    push(base + 2, "clr_alone_hold", 2'd3, 1'b1, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL %s edge %0d: observed %h, required %h", e.name, cyc, obs(), e.v);
        end
      end
      if (k == 1) clr_err = 1'b0;
    end
  endtask

  // Five RUN losses: 2-bit counter must read 1,2,3,3,3.
  task automatic test_saturate();
    exp_t e;
    int   base;
    for (int i = 0; i < 5; i++) begin
      base       = cyc;
      locked_raw = 1'b0;
      model_loss();
      push(base + LOSS_LAT,      $sformatf("sat_loss%0d", i), 2'd3 - 2'd3, 1'b0, 1'b1);
      push(base + LOSS_LAT + 15, $sformatf("sat_run%0d", i),  2'd3, 1'b1, 1'b1);
      for (int k = 1; k <= LOSS_LAT + 15; k++) begin
        tick();
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          n_chk++;
          if (obs() !== e.v) begin
            n_fail++;
            $display("FAIL %s edge %0d: observed %h, required %h", e.name, cyc, obs(), e.v);
          end
        end
        if (k == LOSS_LAT) locked_raw = 1'b1;
      end
    end
  endtask

  // clr_err on the loss edge: loss wins, count restarts at 1.
  task automatic test_clr_same_edge();
    exp_t e;
    int   base;
    base       = cyc;
    locked_raw = 1'b0;
    c8 = 1;
    c2 = 1;
    push(base + LOSS_LAT,      "clr_loss_edge", 2'd0, 1'b0, 1'b1);
    push(base + LOSS_LAT + 1,  "clr_loss_after", 2'd0, 1'b0, 1'b1);
    push(base + LOSS_LAT + 15, "clr_loss_rerun", 2'd3, 1'b1, 1'b1);
    for (int k = 1; k <= LOSS_LAT + 15; k++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL %s edge %0d: observed %h, required %h", e.name, cyc, obs(), e.v);
        end
      end
      if (k == LOSS_LAT - 1) clr_err = 1'b1;
      if (k == LOSS_LAT) begin
        clr_err    = 1'b0;
        locked_raw = 1'b1;
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   base;
    n_chk++;
    if (st8 !== 2'd3 || r8 !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_precond: observed state %0d rst_out_n %b, required 3 1", st8, r8);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs() !== 20'h0) begin
      n_fail++;
      $display("FAIL areset_immediate: observed %h, required %h", obs(), 20'h0);
    end
    c8 = 0;
    c2 = 0;
    #2;
    rst_n = 1'b1;
    base  = cyc;
    push(base + 2,  "areset_sync_wait", 2'd0, 1'b0, 1'b0);
    push(base + 3,  "areset_stable",    2'd1, 1'b0, 1'b0);
    push(base + 11, "areset_hold",      2'd2, 1'b0, 1'b0);
    push(base + 14, "areset_hold_end",  2'd2, 1'b0, 1'b0);
    push(base + 15, "areset_run",       2'd3, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL %s edge %0d: observed %h, required %h", e.name, cyc, obs(), e.v);
        end
      end
    end
  endtask

  // One-cycle low, then a two-cycle low, on locked_raw while in RUN.
  task automatic test_glitch();
    exp_t e;
    int   base;
    int   b_low;
    int   last;
    base       = cyc;
    locked_raw = 1'b0;
`ifdef PLL_SUP_GLITCH_FILTER_EN
    b_low = 6;
    last  = 12;
    push(base + 3, "glitch1_ignored",   2'd3, 1'b1, 1'b0);
    push(base + 4, "glitch1_ignored2",  2'd3, 1'b1, 1'b0);
    push(base + 6, "glitch1_still_run", 2'd3, 1'b1, 1'b0);
    push(base + b_low + 3, "glitch2_pending", 2'd3, 1'b1, 1'b0);
    model_loss();
    push(base + b_low + 4, "glitch2_exit",    2'd0, 1'b0, 1'b1);
    push(base + b_low + 5, "glitch2_restable", 2'd1, 1'b0, 1'b1);
`else
    b_low = 16;
    last  = 22;
    push(base + 2, "glitch1_pending", 2'd3, 1'b1, 1'b0);
    model_loss();
    push(base + 3,  "glitch1_exit",     2'd0, 1'b0, 1'b1);
    push(base + 4,  "glitch1_restable", 2'd1, 1'b0, 1'b1);
    push(base + 16, "glitch1_rerun",    2'd3, 1'b1, 1'b1);
    model_loss();
    push(base + b_low + 3, "glitch2_exit",     2'd0, 1'b0, 1'b1);
    push(base + b_low + 4, "glitch2_wait",     2'd0, 1'b0, 1'b1);
    push(base + b_low + 5, "glitch2_restable", 2'd1, 1'b0, 1'b1);
`endif
    for (int k = 1; k <= last; k++) begin
      tick();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_chk++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL %s edge %0d: observed %h, required %h", e.name, cyc, obs(), e.v);
        end
      end
      if (k == 1)         locked_raw = 1'b1;
      if (k == b_low)     locked_raw = 1'b0;
      if (k == b_low + 2) locked_raw = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_qual_drop();
    test_lock_up();
    test_run_loss();
    test_clr_err();
    test_saturate();
    test_clr_same_edge();
    test_async_reset();
    test_glitch();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
